// File: rtl/seq_compare_unit_pkg.sv
// Shared types and sizing helpers for the chunked magnitude comparator.
// Used by seq_compare_unit (build option: SEQ_CMP_EARLY_EXIT_EN).
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a one-bit index register.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_compare_unit_if.sv
// Request/response handshake bundle between the compare stage and seq_compare_unit.
// The master drives operands and out_ready; the slave (the comparator) drives flags.
interface seq_compare_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             signed_i;
  logic             abort_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             less_o;
  logic             equal_o;

  modport master (
    output in_valid_i, src1_i, src2_i, signed_i, abort_i, out_ready_i,
    input  in_ready_o, out_valid_o, less_o, equal_o
  );

  modport slave (
    input  in_valid_i, src1_i, src2_i, signed_i, abort_i, out_ready_i,
    output in_ready_o, out_valid_o, less_o, equal_o
  );
endinterface

// File: rtl/seq_compare_unit_cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice of each operand.
// Shared by every RUN cycle of seq_compare_unit; the caller selects the slice.
module cmp_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             lt_o,
  output logic             eq_o
);

  assign lt_o = (a_i < b_i);
  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/seq_compare_unit.sv
// Multi-cycle signed/unsigned magnitude comparator, MSB chunk first.
// Build option SEQ_CMP_EARLY_EXIT_EN: finish on the first differing chunk.
module seq_compare_unit
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  seq_compare_unit_if.slave bus
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_e                      state_q;
  logic [WIDTH-1:0]            a_q, b_q, a_d, b_d;
  logic [IDX_W-1:0]            idx_q;
  logic                        decided_q, less_q, equal_q, out_valid_q;
  logic [NCHUNK-1:0][CHUNK-1:0] a_chunks, b_chunks;
  logic [CHUNK-1:0]            a_chunk, b_chunk;
  logic                        chunk_lt, chunk_eq, run_done;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    a_d = bus.src1_i;
    b_d = bus.src2_i;
    if (bus.signed_i) begin
      a_d[WIDTH-1] = ~bus.src1_i[WIDTH-1];
      b_d[WIDTH-1] = ~bus.src2_i[WIDTH-1];
    end
  end

  assign a_chunks = a_q;
  assign b_chunks = b_q;
  assign a_chunk  = a_chunks[idx_q];
  assign b_chunk  = b_chunks[idx_q];

  cmp_chunk #(.CHUNK(CHUNK)) u_cmp_chunk (
    .a_i  (a_chunk),
    .b_i  (b_chunk),
    .lt_o (chunk_lt),
    .eq_o (chunk_eq)
  );

`ifdef SEQ_CMP_EARLY_EXIT_EN
  assign run_done = (idx_q == '0) || (!decided_q && !chunk_eq);
`else
  assign run_done = (idx_q == '0);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      decided_q   <= 1'b0;
      less_q      <= 1'b0;
      equal_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.abort_i) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid_i) begin
            state_q   <= RUN;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= LAST_IDX;
            decided_q <= 1'b0;
            less_q    <= 1'b0;
            equal_q   <= 1'b1;
          end
        end
        RUN: begin
          // First differing chunk decides; later chunks are ignored.
          if (!decided_q && !chunk_eq) begin
            decided_q <= 1'b1;
            equal_q   <= 1'b0;
            less_q    <= chunk_lt;
          end
          idx_q <= idx_q - 1'b1;
          if (run_done) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.out_valid_o = out_valid_q;
  assign bus.less_o      = less_q;
  assign bus.equal_o     = equal_q;

endmodule

// File: tb/tb_seq_compare_unit.sv
// Scoreboard bench for seq_compare_unit: directed operands with hand-computed flags
// and latencies; honours SEQ_CMP_EARLY_EXIT_EN when the build defines it.
module tb_seq_compare_unit;

  localparam int WIDTH = 32;
`ifdef SEQ_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic  less;
    logic  equal;
    int    lat;
    string name;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  int   mon_cyc = 0;
  int   mon_acc = 0;
  int   mon_lat = 0;
  bit   mon_was_valid = 1'b0;
  exp_t mon_e;

  seq_compare_unit_if #(.WIDTH(WIDTH)) bus ();

  seq_compare_unit #(.WIDTH(WIDTH), .CHUNK(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lat(input int base, input int early);
    return EARLY ? early : base;
  endfunction

  // Monitor: tracks accept time and consumes results against the scoreboard.
  initial begin
    forever begin
      @(negedge clk_i);
      #1;
      mon_cyc++;
      if (!rst_i) begin
        mon_was_valid = 1'b0;
      end else begin
        if (bus.in_valid_i && bus.in_ready_o) mon_acc = mon_cyc;
        if (bus.out_valid_o && !mon_was_valid) mon_lat = mon_cyc - mon_acc - 1;
        mon_was_valid = bus.out_valid_o;
        if (bus.out_valid_o && bus.out_ready_i) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", bus.out_valid_o, 0);
          end else begin
            mon_e = exp_q.pop_front();
            check({mon_e.name, "_less"},    bus.less_o,  mon_e.less);
            check({mon_e.name, "_equal"},   bus.equal_o, mon_e.equal);
            check({mon_e.name, "_latency"}, mon_lat,     mon_e.lat);
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk_i);
    check("ready_at_issue", bus.in_ready_o, 1);
    bus.in_valid_i = 1'b1;
    bus.src1_i     = a;
    bus.src2_i     = b;
    bus.signed_i   = s;
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic less, input logic equal, input int l);
    exp_t e;
    e.less = less; e.equal = equal; e.lat = l; e.name = name;
    exp_q.push_back(e);
    issue(a, b, s);
    wait_drain(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    bus.in_valid_i  = 1'b0;
    bus.src1_i      = '0;
    bus.src2_i      = '0;
    bus.signed_i    = 1'b0;
    bus.abort_i     = 1'b0;
    bus.out_ready_i = 1'b1;
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_valid", bus.out_valid_o, 0);
    check("rst_less",  bus.less_o,      0);
    check("rst_equal", bus.equal_o,     0);
    check("rst_ready", bus.in_ready_o,  1);
    rst_i = 1'b1;

    run_op("early",       32'h10000000, 32'h20000000, 1'b0, 1'b1, 1'b0, lat(8, 1));
    run_op("neg_signed",  32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1, 1'b0, lat(8, 1));
    run_op("neg_unsign",  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, lat(8, 1));
    run_op("equal_u",     32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 8);
    run_op("equal_s",     32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 8);
    run_op("lsb_diff",    32'h12345678, 32'h12345679, 1'b0, 1'b1, 1'b0, 8);
    run_op("neg_pair",    32'hFFFFFFFB, 32'hFFFFFFFD, 1'b1, 1'b1, 1'b0, 8);
    run_op("min_max_s",   32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, lat(8, 1));
    run_op("min_max_u",   32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, lat(8, 1));
    run_op("greater_mid", 32'h00000050, 32'h00000040, 1'b0, 1'b0, 1'b0, lat(8, 7));

    // Backpressure in DONE with a request pulsed meanwhile.
    e.less = 1'b1; e.equal = 1'b0; e.lat = lat(8, 7); e.name = "bp";
    exp_q.push_back(e);
    bus.out_ready_i = 1'b0;
    issue(32'h00000040, 32'h00000050, 1'b0);
    n = 0;
    while (!bus.out_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("bp_valid_rise", bus.out_valid_o, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", bus.out_valid_o, 1);
      check("bp_hold_less",  bus.less_o,      1);
      check("bp_hold_equal", bus.equal_o,     0);
      check("bp_hold_ready", bus.in_ready_o,  0);
      bus.in_valid_i = (i >= 1 && i <= 3);
      bus.src1_i     = 32'h0;
      bus.src2_i     = 32'h1;
      @(negedge clk_i);
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_idle_ready", bus.in_ready_o,  1);
    check("bp_idle_valid", bus.out_valid_o, 0);
    repeat (10) @(negedge clk_i);
    check("bp_no_accept", bus.in_ready_o, 1);
    check("bp_drained",   exp_q.size(),   0);

    // Abort sampled at the end of the third RUN cycle.
    issue(32'h00000005, 32'h00000006, 1'b0);
    repeat (2) @(negedge clk_i);
    bus.abort_i = 1'b1;
    @(negedge clk_i);
    bus.abort_i = 1'b0;
    check("abort_ready", bus.in_ready_o,  1);
    check("abort_valid", bus.out_valid_o, 0);
    repeat (12) @(negedge clk_i);
    check("abort_still_idle", bus.out_valid_o, 0);
    run_op("after_abort", 32'h00000003, 32'h00000003, 1'b0, 1'b0, 1'b1, 8);

    // Reset for one edge in the middle of RUN.
    issue(32'h00000005, 32'h00000006, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    check("midrst_valid", bus.out_valid_o, 0);
    check("midrst_less",  bus.less_o,      0);
    check("midrst_equal", bus.equal_o,     0);
    check("midrst_ready", bus.in_ready_o,  1);
    repeat (12) @(negedge clk_i);
    check("midrst_no_stale", bus.out_valid_o, 0);
    run_op("after_rst", 32'h00000007, 32'h00000002, 1'b1, 1'b0, 1'b0, 8);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
